// File: rtl/cpu31_pkg.sv
// Shared constants and types for the CPU31 fetch / IF-ID boundary.
package cpu31_pkg;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNC_HI  = 5;
    localparam int FUNC_LO  = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JADDR_HI = 25;
    localparam int JADDR_LO = 0;

    typedef enum logic {
        FETCH,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous flush, enable-gated load, bubble when no word arrives.
module if_id_reg
    import cpu31_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [31:0]       i_instr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [31:0]       o_instr
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP_WORD;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP_WORD;
        end else if (i_en) begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_pc    <= i_pc;
                r_instr <= i_instr;
            end else begin
                // ID consumed the old word and nothing new arrived: insert a bubble.
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/if_id_stage.sv
// CPU31 fetch stage: PC, fetch FSM, instruction-memory handshake and IF/ID field split.
module if_id_stage
    import cpu31_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu31_pkg::RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4,
    output logic [31:0]       id_instr,
    output logic [5:0]        id_op,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_func,
    output logic [15:0]       id_imm16,
    output logic [25:0]       id_jaddr,
    output logic              fetch_busy
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_fire;
    logic              w_unused_lsbs;

    assign w_unused_lsbs = ^redirect_pc[1:0];

    assign imem_req   = (r_state == FETCH) && !rst;
    assign imem_addr  = r_pc;
    assign fetch_busy = imem_req && !imem_ready;
    assign w_fire     = imem_req && imem_ready && !stall;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (redirect) begin
            w_state_next = FETCH;
            w_pc_next    = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (stall) begin
            w_state_next = HOLD;
        end else begin
            w_state_next = FETCH;
            if (w_fire) begin
                w_pc_next = r_pc + ADDR_W'(4);
            end
        end
    end

    // Reset parks in HOLD so the first request appears only after the first edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HOLD;
            r_pc    <= ADDR_W'(RESET_PC);
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_en    (!stall),
        .i_flush (redirect),
        .i_load  (w_fire),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .o_valid (id_valid),
        .o_pc    (id_pc),
        .o_instr (id_instr)
    );

    assign id_pc4   = id_pc + ADDR_W'(4);
    assign id_op    = id_instr[OP_HI:OP_LO];
    assign id_rs    = id_instr[RS_HI:RS_LO];
    assign id_rt    = id_instr[RT_HI:RT_LO];
    assign id_rd    = id_instr[RD_HI:RD_LO];
    assign id_shamt = id_instr[SHAMT_HI:SHAMT_LO];
    assign id_func  = id_instr[FUNC_HI:FUNC_LO];
    assign id_imm16 = id_instr[IMM_HI:IMM_LO];
    assign id_jaddr = id_instr[JADDR_HI:JADDR_LO];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus queues expected IF/ID contents, a monitor checks captures.
module tb_if_id_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_func;
    logic [15:0] id_imm16;
    logic [25:0] id_jaddr;
    logic        fetch_busy;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_instr    (id_instr),
        .id_op       (id_op),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_func     (id_func),
        .id_imm16    (id_imm16),
        .id_jaddr    (id_jaddr),
        .fetch_busy  (fetch_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: a handshake seen before an edge must show up in IF/ID right after it.
    initial begin
        logic hs;
        exp_t e;
        forever begin
            @(negedge clk);
            hs = imem_req && imem_ready && !stall && !redirect && !rst;
            @(posedge clk);
            #1;
            if (hs) begin
                if (q.size() == 0) begin
                    chk("unexpected_capture", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_valid", {31'd0, id_valid}, 32'd1);
                    chk("sb_pc", id_pc, e.pc);
                    chk("sb_pc4", id_pc4, e.pc + 32'd4);
                    chk("sb_instr", id_instr, e.instr);
                    chk("sb_op", {26'd0, id_op}, {26'd0, e.instr[31:26]});
                    chk("sb_rs", {27'd0, id_rs}, {27'd0, e.instr[25:21]});
                    chk("sb_rt", {27'd0, id_rt}, {27'd0, e.instr[20:16]});
                    chk("sb_rd", {27'd0, id_rd}, {27'd0, e.instr[15:11]});
                    chk("sb_shamt", {27'd0, id_shamt}, {27'd0, e.instr[10:6]});
                    chk("sb_func", {26'd0, id_func}, {26'd0, e.instr[5:0]});
                    chk("sb_imm16", {16'd0, id_imm16}, {16'd0, e.instr[15:0]});
                    chk("sb_jaddr", {6'd0, id_jaddr}, {6'd0, e.instr[25:0]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        tick(); tick();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0040_0000);
        chk("rst_fields", {id_op, id_rs, id_rt, id_rd, id_shamt, id_func}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1 chk("pre_first_edge_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0040_0000);
        imem_ready = 1'b1; imem_rdata = 32'h3C01_1234;
        q.push_back('{pc: 32'h0040_0000, instr: 32'h3C01_1234});
        tick();
        chk("lui_imm16", {16'd0, id_imm16}, 32'h0000_1234);
        chk("lui_rt", {27'd0, id_rt}, 32'd1);
        chk("lui_op", {26'd0, id_op}, 32'h0000_000F);
        chk("pc_adv", imem_addr, 32'h0040_0004);
        imem_rdata = 32'h8C22_0004;
        q.push_back('{pc: 32'h0040_0004, instr: 32'h8C22_0004});
        tick();

        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_busy", {31'd0, fetch_busy}, 32'd1);
            chk("wait_addr", imem_addr, 32'h0040_0008);
            tick();
            chk("wait_bubble", {31'd0, id_valid}, 32'd0);
        end
        imem_ready = 1'b1; imem_rdata = 32'h2108_FFFF;
        q.push_back('{pc: 32'h0040_0008, instr: 32'h2108_FFFF});
        tick();

        stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_instr", id_instr, 32'h2108_FFFF);
            chk("stall_pc", id_pc, 32'h0040_0008);
            chk("stall_valid", {31'd0, id_valid}, 32'd1);
            chk("stall_imm", {16'd0, id_imm16}, 32'h0000_FFFF);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h0040_000C);
        imem_rdata = 32'h0022_1820;
        q.push_back('{pc: 32'h0040_000C, instr: 32'h0022_1820});
        tick();

        redirect = 1'b1; redirect_pc = 32'h0040_0103; stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_instr", id_instr, 32'h0);
        chk("redir_addr", imem_addr, 32'h0040_0100);
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        redirect = 1'b0; stall = 1'b0; imem_rdata = 32'h2401_0005;
        q.push_back('{pc: 32'h0040_0100, instr: 32'h2401_0005});
        tick();

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ready = 1'b0;
        tick();
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_000C;
        q.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h0000_000C});
        tick();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", id_pc4, 32'h0000_0000);

        imem_ready = 1'b0;
        #1 chk("pre_rst_busy", {31'd0, fetch_busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, id_valid}, 32'd0);
        chk("async_instr", id_instr, 32'h0);
        chk("async_pc", id_pc, 32'h0);
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_busy", {31'd0, fetch_busy}, 32'd0);
        chk("async_addr", imem_addr, 32'h0040_0000);
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0040_0000);
        imem_ready = 1'b1; imem_rdata = 32'h0000_0000;
        q.push_back('{pc: 32'h0040_0000, instr: 32'h0000_0000});
        tick();
        imem_ready = 1'b0;
        tick();
        chk("queue_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
